// File: rtl/rr_select_arbiter32.sv
// Round-robin arbiter over 32 request lines. Produces a registered binary
// select and one-hot grant for a downstream 32:1 mux, held stable behind a
// valid/ready handshake, with an optional timeout that withdraws a grant the
// consumer never accepts.
module rr_select_arbiter32 #(
  parameter int unsigned TIMEOUT = 0  // 0 disables the timeout; legal 0..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  input  logic        sel_ready,
  output logic [4:0]  sel,
  output logic [31:0] grant,
  output logic        sel_valid,
  output logic        timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] grant_q, grant_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;

  logic [4:0]  pick;
  logic        timeout_hit;

  // Rotating priority search: first set request at or after ptr, mod 32.
  always_comb begin
    pick = ptr_q;
    // Walk from the farthest offset down so the nearest set bit wins last.
    for (int i = 31; i >= 0; i--) begin
      if (req[ptr_q + 5'(i)]) begin
        pick = ptr_q + 5'(i);
      end
    end
  end

  // The wait counter is about to reach TIMEOUT on this edge.
  assign timeout_hit = (TIMEOUT != 0) && ({24'd0, wait_q} + 32'd1 == TIMEOUT);

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    // NOTE: every target gets a default before the case, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d = 8'd0;
        if (req != 32'd0) begin
          sel_d   = pick;
          grant_d = 32'd1 << pick;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (sel_ready) begin
          // Handshake wins over a simultaneous timeout.
          ptr_d   = sel_q + 5'd1;
          grant_d = 32'd0;
          wait_d  = 8'd0;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          ptr_d     = sel_q + 5'd1;
          grant_d   = 32'd0;
          wait_d    = 8'd0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 5'd0;
      grant_q   <= 32'd0;
      ptr_q     <= 5'd0;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign sel_valid = (state_q == S_GRANT);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter32.sv
// Self-checking bench for rr_select_arbiter32. One instance runs with the
// timeout disabled and is watched by a grant scoreboard; a second instance
// with TIMEOUT = 4 covers grant withdrawal and handshake-beats-timeout.
module tb_rr_select_arbiter32;

  logic clk;

  // Instance without timeout
  logic        rst0, rdy0, valid0, to0;
  logic [31:0] req0, grant0;
  logic [4:0]  sel0;

  // Instance with TIMEOUT = 4
  logic        rst4, rdy4, valid4, to4;
  logic [31:0] req4, grant4;
  logic [4:0]  sel4;

  int n_cmp = 0;
  int n_err = 0;

  // Expected grant indices for instance 0, in order.
  int unsigned exp_q[$];

  rr_select_arbiter32 #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .sel_ready(rdy0),
    .sel(sel0), .grant(grant0), .sel_valid(valid0), .timeout(to0)
  );

  rr_select_arbiter32 #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .sel_ready(rdy4),
    .sel(sel4), .grant(grant4), .sel_valid(valid4), .timeout(to4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every new grant on instance 0 (valid rising) pops one entry.
  logic prev_valid0 = 1'b0;
  always @(negedge clk) begin
    if (valid0 === 1'b1 && prev_valid0 !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_grant", {27'd0, sel0}, 32'hFFFF_FFFF);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        check("sb_sel", {27'd0, sel0}, e);
        check("sb_grant", grant0, 32'd1 << e);
      end
    end
    prev_valid0 <= valid0;
  end

  initial begin
    int cnt;
    bit seen_to;

    rst0 = 1'b1; req0 = '0; rdy0 = 1'b0;
    rst4 = 1'b1; req4 = '0; rdy4 = 1'b0;

    // Reset then idle
    tick(); tick();
    rst0 = 1'b0; rst4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_sel", {27'd0, sel0}, 32'd0);
      check("idle_grant", grant0, 32'd0);
      check("idle_valid", {31'd0, valid0}, 32'd0);
      check("idle_timeout", {31'd0, to0}, 32'd0);
    end

    // Single request: grant, handshake, one bubble, re-grant of the same line
    exp_q.push_back(5);
    exp_q.push_back(5);
    req0 = 32'h0000_0020; rdy0 = 1'b1;
    tick();
    check("single_valid", {31'd0, valid0}, 32'd1);
    check("single_sel", {27'd0, sel0}, 32'd5);
    tick();
    check("single_bubble", {31'd0, valid0}, 32'd0);
    check("bubble_grant", grant0, 32'd0);
    tick();
    check("single_regrant", {31'd0, valid0}, 32'd1);
    req0 = '0;
    tick();
    check("single_release", {31'd0, valid0}, 32'd0);

    // Round-robin and wrap from ptr = 0
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(31);
    exp_q.push_back(0); exp_q.push_back(1);
    req0 = 32'h8000_0003; rdy0 = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    req0 = '0;
    tick(); tick();
    check("rr_drained", exp_q.size(), 32'd0);

    // Stall and hold (ptr = 2 now); req changes mid-stall
    exp_q.push_back(8);
    req0 = 32'h0000_0100; rdy0 = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_sel", {27'd0, sel0}, 32'd8);
      check("stall_grant", grant0, 32'h0000_0100);
      check("stall_valid", {31'd0, valid0}, 32'd1);
      if (i == 4) req0 = 32'h0000_0001;
      tick();
    end
    check("stall_end_sel", {27'd0, sel0}, 32'd8);
    rdy0 = 1'b1; req0 = '0;
    tick();
    check("stall_release", {31'd0, valid0}, 32'd0);
    check("stall_no_timeout", {31'd0, to0}, 32'd0);

    // Reset mid-grant after two handshakes
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    req0 = 32'hFFFF_FFFF; rdy0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_sel", {27'd0, sel0}, 32'd2);
    rdy0 = 1'b0; rst0 = 1'b1;
    tick();
    check("mid_reset_sel", {27'd0, sel0}, 32'd0);
    check("mid_reset_grant", grant0, 32'd0);
    check("mid_reset_valid", {31'd0, valid0}, 32'd0);
    check("mid_reset_timeout", {31'd0, to0}, 32'd0);
    exp_q.push_back(0);
    rst0 = 1'b0; rdy0 = 1'b1;
    tick();
    check("post_reset_sel", {27'd0, sel0}, 32'd0);
    req0 = '0;
    tick(); tick();

    // Timeout: valid for exactly 4 cycles, then a one-cycle pulse
    req4 = 32'h0000_0004; rdy4 = 1'b0;
    cnt = 0; seen_to = 1'b0;
    for (int i = 0; i < 20 && !seen_to; i++) begin
      tick();
      if (valid4) begin
        cnt++;
        check("to_sel", {27'd0, sel4}, 32'd2);
        check("to_grant", grant4, 32'h0000_0004);
      end
      if (to4) begin
        seen_to = 1'b1;
        check("to_valid_with_pulse", {31'd0, valid4}, 32'd0);
        check("to_grant_with_pulse", grant4, 32'd0);
      end
    end
    check("to_pulse_seen", {31'd0, seen_to}, 32'd1);
    check("to_valid_cycles", cnt, 32'd4);
    req4 = '0;
    tick();
    check("to_pulse_width", {31'd0, to4}, 32'd0);

    // Handshake on the would-be timeout edge wins
    req4 = 32'h0000_0004; rdy4 = 1'b0;
    tick();
    check("hs_grant", {31'd0, valid4}, 32'd1);
    tick(); tick(); tick();
    check("hs_still_valid", {31'd0, valid4}, 32'd1);
    rdy4 = 1'b1; req4 = '0;
    tick();
    check("hs_valid_drop", {31'd0, valid4}, 32'd0);
    check("hs_no_timeout", {31'd0, to4}, 32'd0);
    tick();
    check("hs_no_timeout_late", {31'd0, to4}, 32'd0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
